// File: rtl/bram_bank_rd_mux.sv
// Pipelined bank read-data selector: delays each request's bank select by RD_LAT, then registers the bank's word.
// Latency RD_LAT+1 cycles from request to rd_valid; no backpressure, the pipeline advances every cycle.
module bram_bank_rd_mux #(
  parameter int NUM_BANKS = 4,
  parameter int DATA_W    = 8,
  parameter int SEL_W     = 2,
  parameter int RD_LAT    = 1,
  parameter int HOLD_LAST = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        req_valid,
  input  logic [SEL_W-1:0]            req_bank,
  input  logic [NUM_BANKS*DATA_W-1:0] dout_bus,
  output logic [DATA_W-1:0]           rd_data,
  output logic                        rd_valid,
  output logic [SEL_W-1:0]            rd_bank,
  output logic                        bank_err,
  output logic [7:0]                  err_cnt
);

  logic [RD_LAT-1:0] stg_valid;
  logic [SEL_W-1:0]  stg_bank [RD_LAT];

  logic              last_valid;
  logic [SEL_W-1:0]  last_bank;
  logic [DATA_W-1:0] sel_word;
  logic              sel_ok;

  assign last_valid = stg_valid[RD_LAT-1];
  assign last_bank  = stg_bank[RD_LAT-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stg_valid <= '0;
      for (int i = 0; i < RD_LAT; i++) stg_bank[i] <= '0;
    end else begin
      stg_valid[0] <= req_valid;
      stg_bank[0]  <= req_bank;
      for (int i = 1; i < RD_LAT; i++) begin
        stg_valid[i] <= stg_valid[i-1];
        stg_bank[i]  <= stg_bank[i-1];
      end
    end
  end

  // Banks at or above NUM_BANKS match no arm, leaving sel_ok low and the word zero.
  always_comb begin
    sel_word = '0;
    sel_ok   = 1'b0;
    for (int k = 0; k < NUM_BANKS; k++) begin
      if (last_bank == SEL_W'(k)) begin
        sel_word = dout_bus[k*DATA_W +: DATA_W];
        sel_ok   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
      rd_bank  <= '0;
      bank_err <= 1'b0;
      err_cnt  <= '0;
    end else if (last_valid) begin
      rd_data  <= sel_word;
      rd_valid <= 1'b1;
      rd_bank  <= last_bank;
      bank_err <= !sel_ok;
      if (!sel_ok && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end else begin
      rd_valid <= 1'b0;
      bank_err <= 1'b0;
      if (HOLD_LAST == 0) rd_data <= '0;
    end
  end

endmodule

// File: tb/tb_bram_bank_rd_mux.sv
// Directed bench: five instances with different parameters share one stimulus stream.
module tb_bram_bank_rd_mux;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic [1:0]  req_bank;
  logic [31:0] dout_bus;

  // 0: defaults, 1: HOLD_LAST=0, 2: RD_LAT=3, 3: NUM_BANKS=3, 4: RD_LAT=2
  logic [7:0] o_data  [5];
  logic       o_valid [5];
  logic [1:0] o_bank  [5];
  logic       o_err   [5];
  logic [7:0] o_cnt   [5];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  bram_bank_rd_mux u_a (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_bank(req_bank), .dout_bus(dout_bus),
    .rd_data(o_data[0]), .rd_valid(o_valid[0]), .rd_bank(o_bank[0]), .bank_err(o_err[0]), .err_cnt(o_cnt[0]));

  bram_bank_rd_mux #(.HOLD_LAST(0)) u_b (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_bank(req_bank), .dout_bus(dout_bus),
    .rd_data(o_data[1]), .rd_valid(o_valid[1]), .rd_bank(o_bank[1]), .bank_err(o_err[1]), .err_cnt(o_cnt[1]));

  bram_bank_rd_mux #(.RD_LAT(3)) u_c (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_bank(req_bank), .dout_bus(dout_bus),
    .rd_data(o_data[2]), .rd_valid(o_valid[2]), .rd_bank(o_bank[2]), .bank_err(o_err[2]), .err_cnt(o_cnt[2]));

  bram_bank_rd_mux #(.NUM_BANKS(3)) u_d (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_bank(req_bank), .dout_bus(dout_bus[23:0]),
    .rd_data(o_data[3]), .rd_valid(o_valid[3]), .rd_bank(o_bank[3]), .bank_err(o_err[3]), .err_cnt(o_cnt[3]));

  bram_bank_rd_mux #(.RD_LAT(2)) u_e (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_bank(req_bank), .dout_bus(dout_bus),
    .rd_data(o_data[4]), .rd_valid(o_valid[4]), .rd_bank(o_bank[4]), .bank_err(o_err[4]), .err_cnt(o_cnt[4]));

  typedef struct {
    logic        rv;
    logic [1:0]  rb;
    logic [31:0] dout;
    logic        ev;
    logic [7:0]  ed_hold;
    logic [7:0]  ed_zero;
    logic [1:0]  eb;
  } vec_t;

  vec_t tbl [12];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] b, input logic [31:0] d);
    req_valid = v;
    req_bank  = b;
    dout_bus  = d;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, 2'd0, 32'h0);
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    // Request in row r is sampled with the dout of row r+1 and visible in row r+1's check.
    tbl[0]  = '{1'b1, 2'd0, 32'hDDCCBBAA, 1'b0, 8'h00, 8'h00, 2'd0};
    tbl[1]  = '{1'b1, 2'd1, 32'hDDCCBBAA, 1'b1, 8'hAA, 8'hAA, 2'd0};
    tbl[2]  = '{1'b1, 2'd2, 32'hDDCCBBAA, 1'b1, 8'hBB, 8'hBB, 2'd1};
    tbl[3]  = '{1'b1, 2'd3, 32'hDDCCBBAA, 1'b1, 8'hCC, 8'hCC, 2'd2};
    tbl[4]  = '{1'b0, 2'd0, 32'hDDCCBBAA, 1'b1, 8'hDD, 8'hDD, 2'd3};
    tbl[5]  = '{1'b1, 2'd1, 32'h00007700, 1'b0, 8'hDD, 8'h00, 2'd3};
    tbl[6]  = '{1'b0, 2'd0, 32'h00007700, 1'b1, 8'h77, 8'h77, 2'd1};
    tbl[7]  = '{1'b0, 2'd1, 32'h11223344, 1'b0, 8'h77, 8'h00, 2'd1};
    tbl[8]  = '{1'b0, 2'd2, 32'h55667788, 1'b0, 8'h77, 8'h00, 2'd1};
    tbl[9]  = '{1'b0, 2'd3, 32'h99AABBCC, 1'b0, 8'h77, 8'h00, 2'd1};
    tbl[10] = '{1'b0, 2'd1, 32'hFFFFFFFF, 1'b0, 8'h77, 8'h00, 2'd1};
    tbl[11] = '{1'b0, 2'd0, 32'h0F0F0F0F, 1'b0, 8'h77, 8'h00, 2'd1};

    // Reset held 3 cycles with requests present, then 2 idle cycles.
    rst_n = 1'b0;
    drive(1'b1, 2'd3, 32'hDDCCBBAA);
    for (int c = 0; c < 3; c++) begin
      step();
      check($sformatf("rst%0d rd_valid", c), 32'(o_valid[0]), 32'd0);
      check($sformatf("rst%0d rd_data", c),  32'(o_data[0]),  32'd0);
      check($sformatf("rst%0d err_cnt", c),  32'(o_cnt[3]),   32'd0);
    end
    rst_n = 1'b1;
    drive(1'b0, 2'd0, 32'hDDCCBBAA);
    for (int c = 0; c < 2; c++) begin
      step();
      check($sformatf("post_rst%0d rd_valid", c), 32'(o_valid[0]), 32'd0);
      check($sformatf("post_rst%0d rd_data", c),  32'(o_data[0]),  32'd0);
      check($sformatf("post_rst%0d bank_err", c), 32'(o_err[3]),   32'd0);
    end

    // Back-to-back reads then hold behaviour, both HOLD_LAST settings.
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].rv, tbl[i].rb, tbl[i].dout);
      step();
      check($sformatf("tbl%0d rd_valid", i),      32'(o_valid[0]), 32'(tbl[i].ev));
      check($sformatf("tbl%0d rd_data", i),       32'(o_data[0]),  32'(tbl[i].ed_hold));
      check($sformatf("tbl%0d rd_bank", i),       32'(o_bank[0]),  32'(tbl[i].eb));
      check($sformatf("tbl%0d bank_err", i),      32'(o_err[0]),   32'd0);
      check($sformatf("tbl%0d nohold rd_valid", i), 32'(o_valid[1]), 32'(tbl[i].ev));
      check($sformatf("tbl%0d nohold rd_data", i),  32'(o_data[1]),  32'(tbl[i].ed_zero));
      check($sformatf("tbl%0d nohold rd_bank", i),  32'(o_bank[1]),  32'(tbl[i].eb));
    end

    // RD_LAT=3: bank 2 word present only in cycle 3.
    do_reset();
    for (int c = 0; c < 8; c++) begin
      drive(c == 0, 2'd2, (c == 3) ? 32'h005A0000 : 32'h00A50000);
      step();
      check($sformatf("lat3 c%0d rd_valid", c), 32'(o_valid[2]), (c == 3) ? 32'd1 : 32'd0);
      if (c == 3) check("lat3 rd_data", 32'(o_data[2]), 32'h5A);
    end

    // NUM_BANKS=3: one good read, one out-of-range, then saturation.
    do_reset();
    drive(1'b1, 2'd2, 32'h00AB0000);
    step();
    drive(1'b1, 2'd3, 32'h00AB0000);
    step();
    check("nb3 good rd_data",  32'(o_data[3]), 32'hAB);
    check("nb3 good bank_err", 32'(o_err[3]),  32'd0);
    drive(1'b0, 2'd0, 32'h00AB0000);
    step();
    check("nb3 bad rd_valid", 32'(o_valid[3]), 32'd1);
    check("nb3 bad rd_data",  32'(o_data[3]),  32'd0);
    check("nb3 bad rd_bank",  32'(o_bank[3]),  32'd3);
    check("nb3 bad bank_err", 32'(o_err[3]),   32'd1);
    check("nb3 bad err_cnt",  32'(o_cnt[3]),   32'd1);
    step();
    check("nb3 err pulse end", 32'(o_err[3]), 32'd0);
    check("nb3 err_cnt hold",  32'(o_cnt[3]), 32'd1);
    for (int n = 0; n < 300; n++) begin
      drive(1'b1, 2'd3, 32'h00AB0000);
      step();
    end
    drive(1'b0, 2'd0, 32'h0);
    step();
    step();
    check("nb3 err_cnt sat", 32'(o_cnt[3]), 32'd255);

    // RD_LAT=2: two requests killed by reset in cycle 2, new request in cycle 4.
    do_reset();
    for (int c = 0; c < 10; c++) begin
      rst_n = (c != 2);
      if (c == 0 || c == 1) drive(1'b1, 2'd1, 32'h0000EE00);
      else if (c == 4)      drive(1'b1, 2'd0, 32'h000000C3);
      else                  drive(1'b0, 2'd0, 32'h000000C3);
      step();
      check($sformatf("midrst c%0d rd_valid", c), 32'(o_valid[4]), (c == 6) ? 32'd1 : 32'd0);
      if (c == 6) check("midrst rd_data", 32'(o_data[4]), 32'hC3);
    end
    rst_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
